// File: rtl/matrix_uart_printer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | matrix_uart_printer                                                        |
// | Streams an MxN byte matrix (1..5 each) to a UART as decimal ASCII text.    |
// | Optional macro PRINT_HEADER_EN prepends an "MxN" header line.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module matrix_uart_printer #(
  parameter logic [7:0] SEP_CHAR = 8'h20,
  parameter logic [7:0] EOL_CHAR = 8'h0A
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         print_start,
  input  logic [199:0] matrix_flat,
  input  logic [2:0]   mat_m,
  input  logic [2:0]   mat_n,
  input  logic         tx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  output logic         busy,
  output logic         done,
  output logic         error
);

  typedef enum logic [3:0] {
    IDLE, LOAD, EMIT_HDR_M, EMIT_HDR_X, EMIT_HDR_N, EMIT_HDR_EOL,
    EMIT_TENS, EMIT_ONES, EMIT_SEP, EMIT_EOL, DONE, ERR
  } state_t;

  state_t         r_state;
  logic [199:0]   r_mat;
  logic [2:0]     r_m;
  logic [2:0]     r_n;
  logic [2:0]     r_i;
  logic [2:0]     r_j;
  logic [4:0]     r_idx;

  logic           w_xfer;
  logic [4:0]     w_nxt_idx;
  logic [7:0]     w_cur_raw;
  logic [7:0]     w_nxt_raw;
  logic [7:0]     w_cur_val;
  logic [7:0]     w_nxt_val;
  logic           w_last_col;
  logic           w_last_row;

  function automatic logic dims_ok(input logic [2:0] m, input logic [2:0] n);
    return (m != 3'd0) && (m <= 3'd5) && (n != 3'd0) && (n <= 3'd5);
  endfunction

  function automatic logic [7:0] sat99(input logic [7:0] v);
    return (v > 8'd99) ? 8'd99 : v;
  endfunction

  // First character of an element: tens digit if two-digit, else the ones digit.
  function automatic logic [7:0] lead_char(input logic [7:0] v);
    return (v >= 8'd10) ? (8'h30 + v / 8'd10) : (8'h30 + v);
  endfunction

  function automatic state_t lead_state(input logic [7:0] v);
    return (v >= 8'd10) ? EMIT_TENS : EMIT_ONES;
  endfunction

  // r_idx is the linear row-major index, so no i*n multiply is needed.
  assign w_xfer     = tx_valid && tx_ready;
  assign w_nxt_idx  = r_idx + 5'd1;
  assign w_cur_raw  = 8'(r_mat >> {r_idx, 3'b000});
  assign w_nxt_raw  = 8'(r_mat >> {w_nxt_idx, 3'b000});
  assign w_cur_val  = sat99(w_cur_raw);
  assign w_nxt_val  = sat99(w_nxt_raw);
  assign w_last_col = (r_j == r_n - 3'd1);
  assign w_last_row = (r_i == r_m - 3'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_mat    <= '0;
      r_m      <= '0;
      r_n      <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_idx    <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (print_start) begin
            r_mat   <= matrix_flat;
            r_m     <= mat_m;
            r_n     <= mat_n;
            r_i     <= '0;
            r_j     <= '0;
            r_idx   <= '0;
            busy    <= dims_ok(mat_m, mat_n);
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (!dims_ok(r_m, r_n)) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            r_state <= ERR;
          end else begin
            tx_valid <= 1'b1;
`ifdef PRINT_HEADER_EN
            tx_data  <= 8'h30 + {5'd0, r_m};
            r_state  <= EMIT_HDR_M;
`else
            tx_data  <= lead_char(w_cur_val);
            r_state  <= lead_state(w_cur_val);
`endif
          end
        end
`ifdef PRINT_HEADER_EN
        EMIT_HDR_M: if (w_xfer) begin
          tx_data <= 8'h78;
          r_state <= EMIT_HDR_X;
        end
        EMIT_HDR_X: if (w_xfer) begin
          tx_data <= 8'h30 + {5'd0, r_n};
          r_state <= EMIT_HDR_N;
        end
        EMIT_HDR_N: if (w_xfer) begin
          tx_data <= EOL_CHAR;
          r_state <= EMIT_HDR_EOL;
        end
        EMIT_HDR_EOL: if (w_xfer) begin
          tx_data <= lead_char(w_cur_val);
          r_state <= lead_state(w_cur_val);
        end
`endif
        EMIT_TENS: if (w_xfer) begin
          tx_data <= 8'h30 + w_cur_val % 8'd10;
          r_state <= EMIT_ONES;
        end
        EMIT_ONES: if (w_xfer) begin
          tx_data <= w_last_col ? EOL_CHAR : SEP_CHAR;
          r_state <= w_last_col ? EMIT_EOL : EMIT_SEP;
        end
        EMIT_SEP: if (w_xfer) begin
          r_j     <= r_j + 3'd1;
          r_idx   <= w_nxt_idx;
          tx_data <= lead_char(w_nxt_val);
          r_state <= lead_state(w_nxt_val);
        end
        EMIT_EOL: if (w_xfer) begin
          r_j <= '0;
          if (w_last_row) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            r_state  <= DONE;
          end else begin
            r_i     <= r_i + 3'd1;
            r_idx   <= w_nxt_idx;
            tx_data <= lead_char(w_nxt_val);
            r_state <= lead_state(w_nxt_val);
          end
        end
        DONE:    r_state <= IDLE;
        ERR:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_uart_printer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_matrix_uart_printer                                                     |
// | Table, directed and random checks of matrix_uart_printer against a model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_matrix_uart_printer;

  localparam logic [7:0] SEP = 8'h20;
  localparam logic [7:0] EOL = 8'h0A;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         print_start = 1'b0;
  logic [199:0] matrix_flat = '0;
  logic [2:0]   mat_m = '0;
  logic [2:0]   mat_n = '0;
  logic         tx_ready = 1'b0;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         busy;
  logic         done;
  logic         error;

  matrix_uart_printer dut (
    .clk(clk), .rst(rst), .print_start(print_start), .matrix_flat(matrix_flat),
    .mat_m(mat_m), .mat_n(mat_n), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         valid_cnt = 0;
  int         busy_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  typedef struct {
    logic [199:0] mat;
    logic [2:0]   m;
    logic [2:0]   n;
    bit           legal;
    int           nbytes;
  } vec_t;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  // Transfers are sampled on the falling edge, between driving edges.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) check("hold_stable", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prev_data});
      if (tx_valid && tx_ready) got.push_back(tx_data);
      if (tx_valid) valid_cnt++;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        check("done_busy_low", {31'd0, busy}, 32'd0);
      end
      if (error) begin
        err_cnt++;
        check("err_quiet", {30'd0, busy, tx_valid}, 32'd0);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [199:0] mk6(input int a0, a1, a2, a3, a4, a5);
    logic [199:0] r;
    r = '0;
    r[7:0] = 8'(a0); r[15:8] = 8'(a1); r[23:16] = 8'(a2);
    r[31:24] = 8'(a3); r[39:32] = 8'(a4); r[47:40] = 8'(a5);
    return r;
  endfunction

  function automatic logic [199:0] rand_mat();
    logic [199:0] r;
    for (int k = 0; k < 25; k++) begin
      case ($urandom_range(0, 2))
        0:       r[k*8 +: 8] = 8'($urandom_range(0, 9));
        1:       r[k*8 +: 8] = 8'($urandom_range(10, 99));
        default: r[k*8 +: 8] = 8'($urandom_range(100, 255));
      endcase
    end
    return r;
  endfunction

  // Reference: the printed text of the matrix, built element by element.
  function automatic void build_exp(input logic [199:0] mat, input int m, input int n);
    int v;
    exp_q.delete();
`ifdef PRINT_HEADER_EN
    exp_q.push_back(8'(48 + m));
    exp_q.push_back(8'h78);
    exp_q.push_back(8'(48 + n));
    exp_q.push_back(EOL);
`endif
    for (int i = 0; i < m; i++) begin
      for (int j = 0; j < n; j++) begin
        v = int'(mat[(i*n + j)*8 +: 8]);
        if (v > 99) v = 99;
        if (v >= 10) exp_q.push_back(8'(48 + v / 10));
        exp_q.push_back(8'(48 + v % 10));
        exp_q.push_back((j == n - 1) ? EOL : SEP);
      end
    end
  endfunction

  task automatic compare_seq(input string name);
    check({name, "_len"}, got.size(), exp_q.size());
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      check({name, "_byte"}, {24'd0, got[k]}, {24'd0, exp_q[k]});
      if (got[k] !== exp_q[k]) break;
    end
  endtask

  task automatic clear_mon();
    got.delete();
    done_cnt = 0; err_cnt = 0; valid_cnt = 0; busy_cnt = 0;
  endtask

  task automatic wait_end(input int ready_pct);
    for (int c = 0; c < 3000 && done_cnt == 0 && err_cnt == 0; c++) begin
      tx_ready = ($urandom_range(0, 99) < ready_pct);
      step();
    end
    tx_ready = 1'b1;
    repeat (3) step();
  endtask

  task automatic run_print(input logic [199:0] mat, input logic [2:0] m, input logic [2:0] n,
                           input bit legal, input int nbytes, input int ready_pct, input string name);
    clear_mon();
    matrix_flat = mat; mat_m = m; mat_n = n; print_start = 1'b1;
    step();
    print_start = 1'b0;
    matrix_flat = rand_mat(); mat_m = 3'($urandom); mat_n = 3'($urandom);
    wait_end(ready_pct);
    if (legal) begin
      build_exp(mat, int'(m), int'(n));
      check({name, "_done"}, done_cnt, 1);
      check({name, "_noerr"}, err_cnt, 0);
      if (nbytes >= 0) check({name, "_count"}, got.size(), nbytes);
      compare_seq(name);
    end else begin
      check({name, "_err"}, err_cnt, 1);
      check({name, "_nodone"}, done_cnt, 0);
      check({name, "_novalid"}, valid_cnt, 0);
      check({name, "_nobusy"}, busy_cnt, 0);
    end
  endtask

  task automatic load_req31_exp();
    logic [7:0] r31[12];
    r31 = '{8'h31, 8'h20, 8'h32, 8'h20, 8'h33, 8'h0A, 8'h34, 8'h20, 8'h35, 8'h20, 8'h36, 8'h0A};
    exp_q.delete();
`ifdef PRINT_HEADER_EN
    exp_q.push_back(8'h32); exp_q.push_back(8'h78); exp_q.push_back(8'h33); exp_q.push_back(8'h0A);
`endif
    for (int k = 0; k < 12; k++) exp_q.push_back(r31[k]);
  endtask

  vec_t vecs[8];
  int   hdr;

  initial begin
`ifdef PRINT_HEADER_EN
    hdr = 4;
`else
    hdr = 0;
`endif
    vecs[0] = '{mk6(1, 2, 3, 4, 5, 6), 3'd2, 3'd3, 1'b1, 12 + hdr};
    vecs[1] = '{mk6(7, 0, 0, 0, 0, 0), 3'd1, 3'd1, 1'b1, 2 + hdr};
    vecs[2] = '{mk6(3, 0, 0, 0, 0, 0), 3'd1, 3'd1, 1'b1, 2 + hdr};
    vecs[3] = '{mk6(42, 0, 0, 0, 0, 0), 3'd1, 3'd2, 1'b1, 5 + hdr};
    vecs[4] = '{mk6(150, 0, 0, 0, 0, 0), 3'd1, 3'd1, 1'b1, 3 + hdr};
    vecs[5] = '{mk6(1, 2, 3, 4, 5, 6), 3'd0, 3'd3, 1'b0, 0};
    vecs[6] = '{mk6(1, 2, 3, 4, 5, 6), 3'd2, 3'd6, 1'b0, 0};
    vecs[7] = '{{25{8'd99}}, 3'd5, 3'd5, 1'b1, 75 + hdr};

    // Reset state
    repeat (3) step();
    @(negedge clk);
    check("reset_outputs", {20'd0, tx_valid, tx_data, busy, done, error}, 32'd0);
    step();
    rst = 1'b0;
    step();

    // First byte latency and busy onset
    clear_mon();
    load_req31_exp();
    matrix_flat = mk6(1, 2, 3, 4, 5, 6); mat_m = 3'd2; mat_n = 3'd3;
    tx_ready = 1'b1; print_start = 1'b1;
    step();
    print_start = 1'b0;
    @(negedge clk);
    check("latency_first_edge", {30'd0, tx_valid, busy}, {30'd0, 1'b0, 1'b1});
    step();
    @(negedge clk);
    check("latency_second_edge", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, exp_q[0]});
    wait_end(100);
    check("req31_done", done_cnt, 1);
    compare_seq("req31_direct");

    // Vector table
    foreach (vecs[k])
      run_print(vecs[k].mat, vecs[k].m, vecs[k].n, vecs[k].legal, vecs[k].nbytes, 100, $sformatf("vec%0d", k));

    // Backpressure with an ignored mid-print request
    clear_mon();
    load_req31_exp();
    matrix_flat = mk6(1, 2, 3, 4, 5, 6); mat_m = 3'd2; mat_n = 3'd3;
    tx_ready = 1'b0; print_start = 1'b1;
    step();
    print_start = 1'b0;
    step();
    @(negedge clk);
    check("bp_valid_up", {31'd0, tx_valid}, 32'd1);
    repeat (5) step();
    matrix_flat = mk6(9, 9, 9, 9, 9, 9); mat_m = 3'd1; mat_n = 3'd1;
    print_start = 1'b1; tx_ready = 1'b1;
    step();
    print_start = 1'b0;
    wait_end(50);
    check("bp_done", done_cnt, 1);
    compare_seq("bp_seq");

    // Reset after the third transfer
    clear_mon();
    matrix_flat = mk6(1, 2, 3, 4, 5, 6); mat_m = 3'd2; mat_n = 3'd3;
    tx_ready = 1'b1; print_start = 1'b1;
    step();
    print_start = 1'b0;
    for (int c = 0; c < 100 && got.size() < 3; c++) step();
    check("rst_pre_count", got.size(), 3);
    rst = 1'b1;
    step();
    @(negedge clk);
    check("rst_mid_outputs", {20'd0, tx_valid, tx_data, busy, done, error}, 32'd0);
    rst = 1'b0;
    valid_cnt = 0; busy_cnt = 0;
    repeat (4) step();
    check("rst_no_partial", valid_cnt + busy_cnt + done_cnt, 0);
    check("rst_no_extra", got.size(), 3);

    // Randomized prints against the model
    for (int r = 0; r < 25; r++) begin
      logic [2:0] rm, rn;
      int pct;
      rm = 3'($urandom_range(0, 6));
      rn = 3'($urandom_range(0, 6));
      case ($urandom_range(0, 2))
        0:       pct = 100;
        1:       pct = 60;
        default: pct = 25;
      endcase
      run_print(rand_mat(), rm, rn, (rm >= 1 && rm <= 5 && rn >= 1 && rn <= 5), -1, pct,
                $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
